// File: rtl/uart_tx_frame_gen_if.sv
// uart_tx_frame_gen_if: word handshake, frame configuration and serial output of the UART transmitter
interface uart_tx_frame_gen_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [4:0]            Prescale;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, Prescale,
        output TX_OUT, Busy
    );
endinterface

// File: rtl/uart_tx_frame_gen.sv
// uart_tx_frame_gen: serializes one word per handshake into a start/data/parity/stop UART frame
module uart_tx_frame_gen #(
    parameter int DATA_WIDTH = 8
) (
    input logic                CLK,
    input logic                Reset,
    uart_tx_frame_gen_if.slave bus
);
    localparam int BW = $clog2(DATA_WIDTH);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;

    logic [2:0]            r_state;
    logic [4:0]            r_presc;
    logic [4:0]            r_cnt;
    logic [BW-1:0]         r_bit;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  r_tx;
    logic                  r_busy;
    logic [4:0]            w_presc_eff;
    logic                  w_bit_end;
    logic                  w_last_bit;

    assign w_presc_eff = (bus.Prescale == 5'd0) ? 5'd1 : bus.Prescale;
    assign w_bit_end   = (r_cnt == r_presc - 5'd1);
    assign w_last_bit  = (r_bit == BW'(DATA_WIDTH - 1));
    assign bus.TX_OUT  = r_tx;
    assign bus.Busy    = r_busy;

    // Prescale counter: restarts at every bit boundary and is held at zero while idle
    always_ff @(posedge CLK) begin
        if (!Reset)
            r_cnt <= 5'd0;
        else
            r_cnt <= (r_state == IDLE || w_bit_end) ? 5'd0 : r_cnt + 5'd1;
    end

    // Frame sequencer: the line value for the next bit is registered at the boundary that starts it
    always_ff @(posedge CLK) begin
        if (!Reset) begin
            r_state   <= IDLE;
            r_presc   <= 5'd0;
            r_bit     <= '0;
            r_data    <= '0;
            r_par_en  <= 1'b0;
            r_par_bit <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (bus.Data_Valid) begin
                    r_state   <= START;
                    r_data    <= bus.P_DATA;
                    r_par_en  <= bus.PAR_EN;
                    r_par_bit <= (^bus.P_DATA) ^ bus.PAR_TYP;
                    r_presc   <= w_presc_eff;
                    r_tx      <= 1'b0;
                    r_busy    <= 1'b1;
                end
                START: if (w_bit_end) begin
                    r_state <= DATA;
                    r_bit   <= '0;
                    r_tx    <= r_data[0];
                end
                DATA: if (w_bit_end) begin
                    if (w_last_bit) begin
                        r_state <= r_par_en ? PARITY : STOP;
                        r_tx    <= r_par_en ? r_par_bit : 1'b1;
                    end else begin
                        r_bit  <= r_bit + 1'b1;
                        r_data <= r_data >> 1;
                        r_tx   <= r_data[1];
                    end
                end
                PARITY: if (w_bit_end) begin
                    r_state <= STOP;
                    r_tx    <= 1'b1;
                end
                STOP: if (w_bit_end) begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// tb_uart_tx_frame_gen: randomized and directed frames checked cycle by cycle against a bit-list model
module tb_uart_tx_frame_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    uart_tx_frame_gen_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_frame_gen #(.DATA_WIDTH(8)) dut (
        .CLK   (clk),
        .Reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic scramble();
        bus.P_DATA   = 8'($urandom);
        bus.PAR_EN   = 1'($urandom);
        bus.PAR_TYP  = 1'($urandom);
        bus.Prescale = 5'($urandom);
    endtask

    task automatic expect_frame(input logic [7:0] d, input bit en, input bit typ, input int p, input bit keep);
        bit q[$];
        int pe;
        pe = (p == 0) ? 1 : p;
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(d[i]);
        if (en) q.push_back(1'(($countones(d) % 2) ^ int'(typ)));
        q.push_back(1'b1);
        for (int k = 0; k < q.size() * pe; k++) begin
            check($sformatf("tx d=%0h k=%0d", d, k), 32'(bus.TX_OUT), 32'(q[k / pe]));
            check($sformatf("busy d=%0h k=%0d", d, k), 32'(bus.Busy), 32'd1);
            if (!keep && k == 0) scramble();
            @(negedge clk);
        end
        check("idle_busy", 32'(bus.Busy), 32'd0);
        check("idle_tx", 32'(bus.TX_OUT), 32'd1);
    endtask

    task automatic send(input logic [7:0] d, input bit en, input bit typ, input int p);
        @(negedge clk);
        bus.P_DATA = d;
        bus.PAR_EN = en;
        bus.PAR_TYP = typ;
        bus.Prescale = 5'(p);
        bus.Data_Valid = 1'b1;
        @(negedge clk);
        bus.Data_Valid = 1'b0;
        expect_frame(d, en, typ, p, 1'b0);
    endtask

    initial begin
        logic [7:0] d;
        bus.Data_Valid = 1'b0;
        scramble();
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(bus.TX_OUT), 32'd1);
        check("rst_busy", 32'(bus.Busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_tx", 32'(bus.TX_OUT), 32'd1);
        send(8'hA5, 1'b1, 1'b0, 4);
        send(8'hA5, 1'b1, 1'b1, 4);
        send(8'hFF, 1'b0, 1'b0, 8);
        send(8'h01, 1'b0, 1'b0, 0);
        send(8'h5A, 1'b1, 1'b0, 1);
        @(negedge clk);
        bus.P_DATA = 8'h3C;
        bus.PAR_EN = 1'b1;
        bus.PAR_TYP = 1'b0;
        bus.Prescale = 5'd3;
        bus.Data_Valid = 1'b1;
        @(negedge clk);
        bus.P_DATA = 8'h81;
        expect_frame(8'h3C, 1'b1, 1'b0, 3, 1'b1);
        @(negedge clk);
        expect_frame(8'h81, 1'b1, 1'b0, 3, 1'b1);
        bus.Data_Valid = 1'b0;
        repeat (2) @(negedge clk);
        check("b2b_quiet_busy", 32'(bus.Busy), 32'd0);
        d = 8'($urandom);
        bus.P_DATA = d;
        bus.PAR_EN = 1'b0;
        bus.Prescale = 5'd4;
        bus.Data_Valid = 1'b1;
        @(negedge clk);
        bus.Data_Valid = 1'b0;
        repeat (17) @(negedge clk);
        check("pre_rst_bit3", 32'(bus.TX_OUT), 32'(d[3]));
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_tx", 32'(bus.TX_OUT), 32'd1);
        check("midrst_busy", 32'(bus.Busy), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("after_rst_tx", 32'(bus.TX_OUT), 32'd1);
        send(8'hC3, 1'b1, 1'b1, 2);
        for (int i = 0; i < 25; i++)
            send(8'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 7)));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
